// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: the {pc, instruction} entry at the default
// 32-bit address width and the instruction size in bytes.
package common;

  localparam int INSTR_BYTES = 4;
  localparam int PKG_XLEN    = 32;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [31:0]         instruction;
  } fetch_entry_type;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous FIFO with flush and occupancy count. A push while full
// is accepted when a pop happens in the same cycle: the head is read out
// combinationally before the slot it occupied is overwritten at the edge.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  T              wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy next state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; flush empties the queue but leaves contents intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= AW'(wr_ptr_q + 1'b1);
      end
      if (do_pop) rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch with a prefetch queue. Owns the fetch PC, issues one read
// per cycle while the queue plus the in-flight read leave room, and enqueues
// each response the cycle after issue. A redirect flushes the queue, squashes
// the response arriving that cycle and restarts fetch at the new PC.
module fetch_queue import common::*; #(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            imem_addr,
  output logic                       imem_req,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            pop, push;
  logic [CW:0]     occ;
  entry_t          head, wentry;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Head is consumed only when decode accepts it and no redirect discards it.
  assign pop  = out_valid && !stall && !redirect;
  // The in-flight response lands this cycle unless squashed by a redirect.
  assign push = inflight_q && !redirect;

  // Slots committed after this cycle, counting the outstanding read.
  assign occ      = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req = !reset && !redirect && (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign wentry.pc          = inflight_pc_q;
  assign wentry.instruction = imem_rdata;

  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instruction;

  // Fetch PC and in-flight tracking; redirect wins over issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (imem_req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory returns (addr << 8) one cycle after a request.
// The scoreboard holds the next PC decode should see; it restarts on reset or
// redirect and advances by 4 on every consumed head.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [31:0]     imem_rdata = '0;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [CW-1:0]   count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [XLEN-1:0] exp_q[$];

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .count       (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr << 8;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic exp_restart(input logic [XLEN-1:0] p);
    exp_q.delete();
    exp_q.push_back(p);
  endtask

  task automatic monitor();
    logic [XLEN-1:0] p, nx;
    logic [31:0]     ei;
    if (out_valid && !stall && !redirect) begin
      p  = exp_q.pop_front();
      ei = p << 8;
      nx = p + 32'd4;
      chk("head_pc", out_pc, p);
      chk("head_instr", out_instr, ei);
      exp_q.push_back(nx);
    end
    if (redirect) exp_restart({redirect_pc[XLEN-1:2], 2'b00});
  endtask

  task automatic tick(input logic s, input logic r, input logic [XLEN-1:0] rp);
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = rp;
    #1;
    monitor();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_req"},   imem_req, 1'b0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_count"}, count, '0);
    chk({tag, "_pc"},    out_pc, 32'h0);
    chk({tag, "_instr"}, out_instr, 32'h0);
  endtask

  // Assert reset between clock edges and check outputs before any edge.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("arst");
  endtask

  task automatic release_reset(input logic s);
    @(negedge clk);
    reset = 1'b0; stall = s; redirect = 1'b0; redirect_pc = '0;
    exp_restart(32'h0);
    #1;
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h0);
  endtask

  initial begin
    int nreq;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1 reset = 1'b1;
    #2;
    check_reset_vals("rst");

    // Free-running fetch from reset.
    release_reset(1'b0);
    for (int k = 1; k < 10; k++) begin
      tick(1'b0, 1'b0, '0);
      chk("seq_addr", imem_addr, 32'(4*k));
      chk("seq_req", imem_req, 1'b1);
      chk("seq_valid", out_valid, (k >= 2));
    end

    // Mid-stream asynchronous reset, then stall from the first cycle.
    async_reset();
    release_reset(1'b1);
    nreq = 1;
    for (int k = 1; k < 8; k++) begin
      tick(1'b1, 1'b0, '0);
      nreq += int'(imem_req);
    end
    chk("stall_nreq", nreq, 4);
    chk("stall_count", count, 3'd4);
    chk("stall_req", imem_req, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, '0);
      chk("drain_valid", out_valid, 1'b1);
    end

    // Redirect with three entries queued and a read in flight.
    tick(1'b0, 1'b1, 32'h200);
    chk("rd_pre_count", count, 3'd3);
    chk("rd_req", imem_req, 1'b0);
    tick(1'b0, 1'b0, '0);
    chk("rd_count", count, 3'd0);
    chk("rd_addr", imem_addr, 32'h200);
    chk("rd_req1", imem_req, 1'b1);
    tick(1'b0, 1'b0, '0);
    chk("rd_valid2", out_valid, 1'b0);
    tick(1'b0, 1'b0, '0);
    chk("rd_valid3", out_valid, 1'b1);
    chk("rd_pc3", out_pc, 32'h200);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, '0);

    // Redirect together with stall, unaligned target.
    tick(1'b1, 1'b1, 32'h20E);
    tick(1'b0, 1'b0, '0);
    chk("rs_addr", imem_addr, 32'h20C);
    chk("rs_count", count, 3'd0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, '0);

    // Fill the queue, drop stall for one cycle, then refill.
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, '0);
    chk("full_count", count, 3'd4);
    tick(1'b0, 1'b0, '0);
    chk("full_pop_req", imem_req, 1'b1);
    tick(1'b1, 1'b0, '0);
    chk("full_count1", count, 3'd3);
    tick(1'b1, 1'b0, '0);
    chk("full_count2", count, 3'd4);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, '0);
      chk("full_drain_valid", out_valid, 1'b1);
    end

    // Address wrap at the top of the address space.
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, '0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, '0);
    chk("wrap_addr1", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, '0);

    // Reset mid-stream again and confirm a clean restart.
    async_reset();
    release_reset(1'b0);
    for (int k = 1; k < 4; k++) begin
      tick(1'b0, 1'b0, '0);
      chk("re_addr", imem_addr, 32'(4*k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
